// File: rtl/func_sweep_ctrl_pkg.sv
// Shared definitions for the function sweep sequencer: FSM encoding,
// vector/table widths, the reference truth table and a priority helper.
package func_sweep_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  localparam int VEC_W   = 3;
  localparam int TABLE_W = 1 << VEC_W;
  localparam int WAIT_W  = 4;

  // Truth table of a & ~(b & c) indexed by {a,b,c}
  localparam logic [TABLE_W-1:0] EXPECT_DEFAULT = 8'h70;

  // Index of the lowest set bit; 0 when no bit is set
  function automatic logic [VEC_W-1:0] lowest_set(input logic [TABLE_W-1:0] bits);
    logic [VEC_W-1:0] idx;
    idx = '0;
    for (int i = TABLE_W - 1; i >= 0; i--) begin
      if (bits[i]) idx = VEC_W'(i);
    end
    return idx;
  endfunction

endpackage

// File: rtl/func_sweep_ctrl_func_unit.sv
// Combinational function unit under test: s = a & ~(b & c).
module func_unit (
  input  logic i_a,
  input  logic i_b,
  input  logic i_c,
  output logic o_s
);

  assign o_s = i_a & ~(i_b & i_c);

endmodule

// File: rtl/func_sweep_ctrl.sv
// Self-running truth-table sweep of func_unit.
// Steps vec through 0..7, waits SETTLE extra cycles per vector, captures
// each result into table_q and raises done at the end of the sweep.
// Optional checker against EXPECT is built when FUNC_SWEEP_CHECK_EN is defined;
// otherwise mismatch and fail_idx are tied low.
//
// state   | meaning
// IDLE    | waiting for start; table_q holds last (possibly partial) result
// RUN     | sweeping vectors, busy=1
// DONE    | sweep complete, done=1, vec held at 7
module func_sweep_ctrl
  import func_sweep_ctrl_pkg::*;
#(
  parameter int                 SETTLE = 0,
  parameter logic [TABLE_W-1:0] EXPECT = EXPECT_DEFAULT
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic               abort,
  output logic               busy,
  output logic               done,
  output logic [VEC_W-1:0]   vec,
  output logic [TABLE_W-1:0] table_q,
  output logic               mismatch,
  output logic [VEC_W-1:0]   fail_idx
);

  localparam logic [WAIT_W-1:0] SETTLE_W = WAIT_W'(SETTLE);
  localparam logic [VEC_W-1:0]  VEC_LAST = VEC_W'(TABLE_W - 1);

  state_t               r_state;
  logic [VEC_W-1:0]     r_vec;
  logic [WAIT_W-1:0]    r_wait;
  logic [TABLE_W-1:0]   r_table;
  logic                 r_busy;
  logic                 r_done;

  logic                 w_s;
  logic                 w_start_acc;
  logic                 w_sample;
  logic                 w_last;
  logic [TABLE_W-1:0]   w_table_next;

  func_unit u_func_unit (
    .i_a (r_vec[2]),
    .i_b (r_vec[1]),
    .i_c (r_vec[0]),
    .o_s (w_s)
  );

  // abort beats sampling, so a sample only counts when abort is low
  assign w_start_acc = start && (r_state != ST_RUN);
  assign w_sample    = (r_state == ST_RUN) && !abort && (r_wait == SETTLE_W);
  assign w_last      = w_sample && (r_vec == VEC_LAST);

  // Table as it will look after the current sample lands
  always_comb begin
    w_table_next        = r_table;
    w_table_next[r_vec] = w_s;
  end

  // Sweep FSM with registered status outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= ST_IDLE;
      r_vec   <= '0;
      r_wait  <= '0;
      r_table <= '0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE, ST_DONE: begin
          if (start) begin
            r_state <= ST_RUN;
            r_vec   <= '0;
            r_wait  <= '0;
            r_table <= '0;
            r_busy  <= 1'b1;
            r_done  <= 1'b0;
          end
        end
        ST_RUN: begin
          if (abort) begin
            r_state <= ST_IDLE;
            r_vec   <= '0;
            r_wait  <= '0;
            r_busy  <= 1'b0;
          end else if (r_wait != SETTLE_W) begin
            r_wait <= r_wait + 1'b1;
          end else begin
            r_table <= w_table_next;
            r_wait  <= '0;
            if (r_vec == VEC_LAST) begin
              r_state <= ST_DONE;
              r_busy  <= 1'b0;
              r_done  <= 1'b1;
            end else begin
              r_vec <= r_vec + 1'b1;
            end
          end
        end
        default: begin
          r_state <= ST_IDLE;
          r_vec   <= '0;
          r_wait  <= '0;
          r_busy  <= 1'b0;
          r_done  <= 1'b0;
        end
      endcase
    end
  end

`ifdef FUNC_SWEEP_CHECK_EN
  logic               r_mismatch;
  logic [VEC_W-1:0]   r_fail_idx;
  logic [TABLE_W-1:0] w_diff;

  assign w_diff = w_table_next ^ EXPECT;

  // Compare the completed table on the edge that raises done
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_mismatch <= 1'b0;
      r_fail_idx <= '0;
    end else if (w_start_acc) begin
      r_mismatch <= 1'b0;
      r_fail_idx <= '0;
    end else if (w_last) begin
      r_mismatch <= |w_diff;
      r_fail_idx <= lowest_set(w_diff);
    end
  end

  assign mismatch = r_mismatch;
  assign fail_idx = r_fail_idx;
`else
  // EXPECT has no effect without the checker; the reduction keeps it referenced
  assign mismatch = 1'b0 & (^EXPECT);
  assign fail_idx = '0;
`endif

  assign busy    = r_busy;
  assign done    = r_done;
  assign vec     = r_vec;
  assign table_q = r_table;

endmodule

// File: tb/tb_func_sweep_ctrl.sv
// Directed bench for func_sweep_ctrl: two instances share clk/rst,
// dut_a with SETTLE=0 and the default table, dut_b with SETTLE=3 and EXPECT=8'h71.
module tb_func_sweep_ctrl;

  logic       clk;
  logic       rst;
  logic       start_a, abort_a, start_b, abort_b;
  logic       busy_a, done_a, mismatch_a, busy_b, done_b, mismatch_b;
  logic [2:0] vec_a, fail_idx_a, vec_b, fail_idx_b;
  logic [7:0] table_a, table_b;

  int n_tests = 0;
  int n_fail  = 0;

`ifdef FUNC_SWEEP_CHECK_EN
  localparam logic EXP_MM_B = 1'b1;
`else
  localparam logic EXP_MM_B = 1'b0;
`endif

  func_sweep_ctrl #(.SETTLE(0)) dut_a (
    .clk(clk), .rst(rst), .start(start_a), .abort(abort_a),
    .busy(busy_a), .done(done_a), .vec(vec_a), .table_q(table_a),
    .mismatch(mismatch_a), .fail_idx(fail_idx_a)
  );

  func_sweep_ctrl #(.SETTLE(3), .EXPECT(8'h71)) dut_b (
    .clk(clk), .rst(rst), .start(start_b), .abort(abort_b),
    .busy(busy_b), .done(done_b), .vec(vec_b), .table_q(table_b),
    .mismatch(mismatch_b), .fail_idx(fail_idx_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // advance one edge and sample 1 time unit later
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1; start_a = 0; abort_a = 0; start_b = 0; abort_b = 0;
    #12;
    chk("rst_busy_a", {7'd0, busy_a}, 8'd0);
    chk("rst_done_a", {7'd0, done_a}, 8'd0);
    chk("rst_vec_a", {5'd0, vec_a}, 8'd0);
    chk("rst_table_a", table_a, 8'h00);
    chk("rst_mm_a", {7'd0, mismatch_a}, 8'd0);
    chk("rst_fidx_a", {5'd0, fail_idx_a}, 8'd0);
    @(negedge clk); rst = 1'b0;

    // abort in IDLE has no effect
    abort_a = 1'b1; tick(); abort_a = 1'b0;
    chk("idle_abort_busy", {7'd0, busy_a}, 8'd0);

    // SETTLE=0 sweep: busy 8 cycles, done at E0+8
    start_a = 1'b1; tick(); start_a = 1'b0;
    chk("s0_busy_e0", {7'd0, busy_a}, 8'd1);
    chk("s0_vec_e0", {5'd0, vec_a}, 8'd0);
    for (int k = 1; k <= 7; k++) begin
      tick();
      chk("s0_busy_run", {7'd0, busy_a}, 8'd1);
      chk("s0_vec_run", {5'd0, vec_a}, 8'(k));
      chk("s0_done_run", {7'd0, done_a}, 8'd0);
    end
    tick();
    chk("s0_done", {7'd0, done_a}, 8'd1);
    chk("s0_busy_end", {7'd0, busy_a}, 8'd0);
    chk("s0_table", table_a, 8'h70);
    chk("s0_vec_end", {5'd0, vec_a}, 8'd7);
    chk("s0_mm", {7'd0, mismatch_a}, 8'd0);
    tick();
    chk("s0_done_hold", {7'd0, done_a}, 8'd1);
    chk("s0_vec_hold", {5'd0, vec_a}, 8'd7);

    // SETTLE=3 sweep with EXPECT=8'h71
    start_b = 1'b1; tick(); start_b = 1'b0;
    tick(); tick(); tick();
    chk("s3_vec_e3", {5'd0, vec_b}, 8'd0);
    tick();
    chk("s3_vec_e4", {5'd0, vec_b}, 8'd1);
    chk("s3_table_e4", table_b, 8'h00);
    for (int k = 5; k <= 31; k++) tick();
    chk("s3_busy_e31", {7'd0, busy_b}, 8'd1);
    chk("s3_done_e31", {7'd0, done_b}, 8'd0);
    chk("s3_vec_e31", {5'd0, vec_b}, 8'd7);
    tick();
    chk("s3_done_e32", {7'd0, done_b}, 8'd1);
    chk("s3_busy_e32", {7'd0, busy_b}, 8'd0);
    chk("s3_table", table_b, 8'h70);
    chk("s3_mm", {7'd0, mismatch_b}, {7'd0, EXP_MM_B});
    chk("s3_fidx", {5'd0, fail_idx_b}, 8'd0);

    // abort four cycles in: samples 0..3 taken, sample 4 pre-empted
    start_a = 1'b1; tick(); start_a = 1'b0;
    chk("ab_done_clr", {7'd0, done_a}, 8'd0);
    tick(); tick(); tick(); tick();
    chk("ab_vec_e4", {5'd0, vec_a}, 8'd4);
    abort_a = 1'b1; tick(); abort_a = 1'b0;
    chk("ab_busy", {7'd0, busy_a}, 8'd0);
    chk("ab_vec", {5'd0, vec_a}, 8'd0);
    chk("ab_done", {7'd0, done_a}, 8'd0);
    chk("ab_table", table_a, 8'h00);
    tick();
    chk("ab_idle_hold", {7'd0, busy_a}, 8'd0);
    start_a = 1'b1; tick(); start_a = 1'b0;
    for (int k = 1; k <= 8; k++) tick();
    chk("ab_restart_done", {7'd0, done_a}, 8'd1);
    chk("ab_restart_table", table_a, 8'h70);

    // start at cycle 3 of a sweep is ignored
    start_a = 1'b1; tick(); start_a = 1'b0;
    tick(); tick();
    start_a = 1'b1; tick(); start_a = 1'b0;
    chk("ign_vec_e3", {5'd0, vec_a}, 8'd3);
    for (int k = 4; k <= 7; k++) tick();
    chk("ign_busy_e7", {7'd0, busy_a}, 8'd1);
    chk("ign_done_e7", {7'd0, done_a}, 8'd0);
    tick();
    chk("ign_done_e8", {7'd0, done_a}, 8'd1);
    chk("ign_table", table_a, 8'h70);

    // start in DONE begins a new sweep
    start_a = 1'b1; tick(); start_a = 1'b0;
    chk("redo_done", {7'd0, done_a}, 8'd0);
    chk("redo_busy", {7'd0, busy_a}, 8'd1);
    chk("redo_vec", {5'd0, vec_a}, 8'd0);
    chk("redo_table", table_a, 8'h00);
    for (int k = 1; k <= 8; k++) tick();
    chk("redo_end_done", {7'd0, done_a}, 8'd1);

    // asynchronous reset between edges mid-sweep
    start_a = 1'b1; tick(); start_a = 1'b0;
    tick(); tick();
    #2 rst = 1'b1;
    #1;
    chk("arst_busy_a", {7'd0, busy_a}, 8'd0);
    chk("arst_vec_a", {5'd0, vec_a}, 8'd0);
    chk("arst_table_a", table_a, 8'h00);
    chk("arst_done_b", {7'd0, done_b}, 8'd0);
    chk("arst_table_b", table_b, 8'h00);
    chk("arst_mm_b", {7'd0, mismatch_b}, 8'd0);
    @(negedge clk); rst = 1'b0;
    tick();
    chk("arst_idle_busy", {7'd0, busy_a}, 8'd0);
    chk("arst_idle_done", {7'd0, done_a}, 8'd0);
    start_a = 1'b1; tick(); start_a = 1'b0;
    for (int k = 1; k <= 8; k++) tick();
    chk("arst_resweep_done", {7'd0, done_a}, 8'd1);
    chk("arst_resweep_table", table_a, 8'h70);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  // global time limit so the bench always terminates
  initial begin
    #20000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
